// File: rtl/masked_thermo_pkg.sv
// Shared constants and FSM encoding for the masked thermostat scheduler.
package masked_thermo_pkg;
  localparam int NZONE_DEF  = 4;
  localparam int RND_W      = 4;
  localparam int PIPE_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/masked_dom_and.sv
// First-order DOM AND gadget on two Boolean shares, one fresh random bit.
// Latency 1 cycle; every partial product is registered before recombination.
module masked_dom_and (
  input  logic clk,
  input  logic rst_n,
  input  logic a0,
  input  logic a1,
  input  logic b0,
  input  logic b1,
  input  logic r,
  output logic z0,
  output logic z1
);
  logic p00, p11, c01, c10;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p00 <= 1'b0;
      p11 <= 1'b0;
      c01 <= 1'b0;
      c10 <= 1'b0;
    end else begin
      p00 <= a0 & b0;
      p11 <= a1 & b1;
      c01 <= (a0 & b1) ^ r;
      c10 <= (a1 & b0) ^ r;
    end
  end

  assign z0 = p00 ^ c01;
  assign z1 = p11 ^ c10;
endmodule

// File: rtl/masked_thermo_sched.sv
// Masked thermostat scheduler: one zone issued per cycle through a 2-stage DOM
// pipeline; results land in per-zone output share slots; done pulses after drain.
module masked_thermo_sched
  import masked_thermo_pkg::*;
#(
  parameter int NZONE = NZONE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NZONE-1:0] too_cold_s0,
  input  logic [NZONE-1:0] too_cold_s1,
  input  logic [NZONE-1:0] too_hot_s0,
  input  logic [NZONE-1:0] too_hot_s1,
  input  logic [NZONE-1:0] mode_s0,
  input  logic [NZONE-1:0] mode_s1,
  input  logic [NZONE-1:0] fan_on_s0,
  input  logic [NZONE-1:0] fan_on_s1,
  input  logic [RND_W-1:0] rnd,
  output logic             busy,
  output logic             done,
  output logic [NZONE-1:0] heater_s0,
  output logic [NZONE-1:0] heater_s1,
  output logic [NZONE-1:0] aircon_s0,
  output logic [NZONE-1:0] aircon_s1,
  output logic [NZONE-1:0] fan_s0,
  output logic [NZONE-1:0] fan_s1
);
  localparam int IW = (NZONE > 1) ? $clog2(NZONE) : 1;
  localparam int DW = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(NZONE - 1);
  localparam logic [DW-1:0] LAST_DRN  = DW'(PIPE_DEPTH - 1);

  state_t        state, state_n;
  logic [IW-1:0] idx, idx_n, idx1, idx2;
  logic [DW-1:0] drn, drn_n;
  logic          done_n, accept, v1, v2;

  logic [NZONE-1:0] sc0, sc1, sh0, sh1, sm0, sm1, sf0, sf1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      drn   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      drn   <= drn_n;
      done  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    drn_n   = drn;
    done_n  = 1'b0;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_n = RUN;
          idx_n   = '0;
        end
      end
      RUN: begin
        if (idx == LAST_IDX) begin
          state_n = DRAIN;
          drn_n   = '0;
        end else begin
          idx_n = idx + IW'(1);
        end
      end
      DRAIN: begin
        if (drn == LAST_DRN) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          drn_n = drn + DW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Snapshot keeps shares separate; the pass then runs off these copies only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {sc0, sc1, sh0, sh1, sm0, sm1, sf0, sf1} <= '0;
    end else if (accept) begin
      sc0 <= too_cold_s0;
      sc1 <= too_cold_s1;
      sh0 <= too_hot_s0;
      sh1 <= too_hot_s1;
      sm0 <= mode_s0;
      sm1 <= mode_s1;
      sf0 <= fan_on_s0;
      sf1 <= fan_on_s1;
    end
  end

  logic hz0, hz1, az0, az1;
  logic fd0, fd1, hd0, hd1, ad0, ad1;
  logic x0, x1, fz0, fz1;

  masked_dom_and u_heater (
    .clk(clk), .rst_n(rst_n),
    .a0(sm0[idx]), .a1(sm1[idx]), .b0(sc0[idx]), .b1(sc1[idx]),
    .r(rnd[0]), .z0(hz0), .z1(hz1)
  );

  // Complementing a shared value only needs one share flipped.
  masked_dom_and u_aircon (
    .clk(clk), .rst_n(rst_n),
    .a0(~sm0[idx]), .a1(sm1[idx]), .b0(sh0[idx]), .b1(sh1[idx]),
    .r(rnd[1]), .z0(az0), .z1(az1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {fd0, fd1, hd0, hd1, ad0, ad1} <= '0;
      {v1, v2, idx1, idx2}          <= '0;
    end else begin
      fd0  <= sf0[idx];
      fd1  <= sf1[idx];
      hd0  <= hz0;
      hd1  <= hz1;
      ad0  <= az0;
      ad1  <= az1;
      v1   <= (state == RUN);
      idx1 <= idx;
      v2   <= v1;
      idx2 <= idx1;
    end
  end

  // heater and aircon are never both 1, so XOR acts as OR share-wise.
  assign x0 = hz0 ^ az0;
  assign x1 = hz1 ^ az1;

  masked_dom_and u_fan (
    .clk(clk), .rst_n(rst_n),
    .a0(~fd0), .a1(fd1), .b0(~x0), .b1(x1),
    .r(rnd[2]), .z0(fz0), .z1(fz1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      heater_s0 <= '0;
      heater_s1 <= '0;
      aircon_s0 <= '0;
      aircon_s1 <= '0;
      fan_s0    <= '0;
      fan_s1    <= '0;
    end else if (v2) begin
      heater_s0[idx2] <= hd0;
      heater_s1[idx2] <= hd1;
      aircon_s0[idx2] <= ad0;
      aircon_s1[idx2] <= ad1;
      fan_s0[idx2]    <= ~fz0 ^ rnd[3];
      fan_s1[idx2]    <= fz1 ^ rnd[3];
    end
  end
endmodule

// File: tb/tb_masked_thermo_sched.sv
// Directed bench for masked_thermo_sched (NZONE=4 and NZONE=1) with a queue of expected unmasked results.
module tb_masked_thermo_sched;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, start1;
  logic [3:0] tc0, tc1, th0, th1, m0, m1, f0, f1, rnd;
  logic       busy, done;
  logic [3:0] h0, h1, a0, a1, fa0, fa1;
  logic [0:0] u_tc0, u_tc1, u_th0, u_th1, u_m0, u_m1, u_f0, u_f1;
  logic       busy1, done1;
  logic [0:0] uh0, uh1, ua0, ua1, ufa0, ufa1;

  masked_thermo_sched #(.NZONE(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .too_cold_s0(tc0), .too_cold_s1(tc1), .too_hot_s0(th0), .too_hot_s1(th1),
    .mode_s0(m0), .mode_s1(m1), .fan_on_s0(f0), .fan_on_s1(f1), .rnd(rnd),
    .busy(busy), .done(done), .heater_s0(h0), .heater_s1(h1),
    .aircon_s0(a0), .aircon_s1(a1), .fan_s0(fa0), .fan_s1(fa1)
  );

  masked_thermo_sched #(.NZONE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .too_cold_s0(u_tc0), .too_cold_s1(u_tc1), .too_hot_s0(u_th0), .too_hot_s1(u_th1),
    .mode_s0(u_m0), .mode_s1(u_m1), .fan_on_s0(u_f0), .fan_on_s1(u_f1), .rnd(rnd),
    .busy(busy1), .done(done1), .heater_s0(uh0), .heater_s1(uh1),
    .aircon_s0(ua0), .aircon_s1(ua1), .fan_s0(ufa0), .fan_s1(ufa1)
  );

  typedef struct packed {
    logic [3:0] h;
    logic [3:0] a;
    logic [3:0] f;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   n1 = 0, ones1 = 0, n0 = 0, ones0 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    rnd = 4'($urandom);
  endtask

  function automatic exp_t model(input logic [3:0] c, hh, m, fo);
    exp_t e;
    e.h = m & c;
    e.a = ~m & hh;
    e.f = fo | e.h | e.a;
    return e;
  endfunction

  task automatic set_in(input logic [3:0] c, hh, m, fo);
    logic [3:0] r;
    r = 4'($urandom); tc0 = r; tc1 = c ^ r;
    r = 4'($urandom); th0 = r; th1 = hh ^ r;
    r = 4'($urandom); m0 = r;  m1 = m ^ r;
    r = 4'($urandom); f0 = r;  f1 = fo ^ r;
  endtask

  // Drives start for one edge (E0) and records what the pass must produce.
  task automatic start_pass(input logic [3:0] c, hh, m, fo);
    set_in(c, hh, m, fo);
    start = 1'b1;
    tick();
    start = 1'b0;
    sb.push_back(model(c, hh, m, fo));
  endtask

  // Entered in the cycle after E0; returns in the done cycle (or on timeout).
  task automatic wait_done(input string tag);
    int n;
    int drops;
    n = 0;
    drops = 0;
    while (n < 30 && !done) begin
      if (!busy) drops++;
      tick();
      n++;
    end
    chk({tag, "_lat"}, n, 6);
    chk({tag, "_busy_mid"}, drops, 0);
    chk({tag, "_busy_done"}, {31'd0, busy}, 0);
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_heater"}, {28'd0, h0 ^ h1}, {28'd0, e.h});
      chk({tag, "_aircon"}, {28'd0, a0 ^ a1}, {28'd0, e.a});
      chk({tag, "_fan"}, {28'd0, fa0 ^ fa1}, {28'd0, e.f});
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start1 = 1'b0; rnd = '0;
    set_in(4'h0, 4'h0, 4'h0, 4'h0);
    {u_tc0, u_tc1, u_th0, u_th1, u_m0, u_m1, u_f0, u_f1} = '0;
    tick(); tick();
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_outs", {h0, h1, a0, a1, fa0, fa1}, 0);
    rst_n = 1'b1;
    tick();

    // Directed zone pattern: z0 heat, z1 cool, z2 fan only, z3 idle.
    start_pass(4'b0001, 4'b0010, 4'b0001, 4'b0100);
    chk("p0_busy_e0", {31'd0, busy}, 1);
    wait_done("p0");
    compare_out("p0");
    chk("p0_h_lit", {28'd0, h0 ^ h1}, 4'b0001);
    chk("p0_a_lit", {28'd0, a0 ^ a1}, 4'b0010);
    chk("p0_f_lit", {28'd0, fa0 ^ fa1}, 4'b0111);
    tick();
    chk("p0_done_pulse", {31'd0, done}, 0);

    // All 16 (cold,hot,mode,fan_on) combos, four zones per pass, several share splits.
    for (int rep = 0; rep < 3; rep++) begin
      for (int p = 0; p < 4; p++) begin
        logic [3:0] c, hh, m, fo;
        for (int z = 0; z < 4; z++) begin
          logic [3:0] combo;
          combo = 4'(p * 4 + z);
          c[z] = combo[0]; hh[z] = combo[1]; m[z] = combo[2]; fo[z] = combo[3];
        end
        start_pass(c, hh, m, fo);
        wait_done("ex");
        compare_out("ex");
        tick();
      end
    end

    // Share statistics: s0 alone should look the same whatever the value.
    for (int p = 0; p < 64; p++) begin
      logic [3:0] c, hh, m, fo;
      c = 4'($urandom); hh = 4'($urandom); m = 4'($urandom); fo = 4'($urandom);
      start_pass(c, hh, m, fo);
      wait_done("st");
      compare_out("st");
      for (int z = 0; z < 4; z++) begin
        if (h0[z] ^ h1[z]) begin n1++; ones1 += int'(h0[z]); end
        else begin n0++; ones0 += int'(h0[z]); end
        if (fa0[z] ^ fa1[z]) begin n1++; ones1 += int'(fa0[z]); end
        else begin n0++; ones0 += int'(fa0[z]); end
      end
      tick();
    end
    chk("s0_unc_v1", {31'd0, (ones1 * 10 > n1 * 3) && (ones1 * 10 < n1 * 7)}, 1);
    chk("s0_unc_v0", {31'd0, (ones0 * 10 > n0 * 3) && (ones0 * 10 < n0 * 7)}, 1);

    // Inputs changed right after E0 must not affect the pass.
    start_pass(4'b1010, 4'b0101, 4'b1100, 4'b0001);
    set_in(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
    wait_done("snap");
    compare_out("snap");
    tick();

    // start held high: accepted only in done cycles, 7-cycle period.
    set_in(4'b1111, 4'b0000, 4'b0011, 4'b0000);
    start = 1'b1;
    tick();
    sb.push_back(model(4'b1111, 4'b0000, 4'b0011, 4'b0000));
    set_in(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
    wait_done("bb1");
    compare_out("bb1");
    set_in(4'b0000, 4'b1111, 4'b0011, 4'b1000);
    tick();
    sb.push_back(model(4'b0000, 4'b1111, 4'b0011, 4'b1000));
    chk("bb_reaccept", {31'd0, busy}, 1);
    wait_done("bb2");
    compare_out("bb2");
    start = 1'b0;
    tick();
    chk("bb_stop", {31'd0, busy}, 0);

    // Reset in the middle of a pass.
    start_pass(4'b1111, 4'b0000, 4'b1111, 4'b1111);
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("mrst_outs", {h0, h1, a0, a1, fa0, fa1}, 0);
    chk("mrst_busy", {31'd0, busy}, 0);
    begin
      int dn;
      dn = 0;
      for (int k = 0; k < 8; k++) begin
        tick();
        if (done) dn++;
      end
      chk("mrst_no_done", dn, 0);
    end
    void'(sb.pop_back());
    rst_n = 1'b1;
    tick();
    start_pass(4'b0110, 4'b1001, 4'b0100, 4'b0010);
    wait_done("post_rst");
    compare_out("post_rst");
    tick();

    // Single-zone instance.
    u_tc0 = 1'($urandom); u_tc1 = ~u_tc0;
    u_th0 = 1'($urandom); u_th1 = u_th0;
    u_m0  = 1'($urandom); u_m1  = ~u_m0;
    u_f0  = 1'($urandom); u_f1  = ~u_f0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    begin
      int n;
      n = 0;
      while (n < 20 && !done1) begin
        tick();
        n++;
      end
      chk("z1_lat", n, 3);
    end
    chk("z1_busy", {31'd0, busy1}, 0);
    chk("z1_heater", {31'd0, uh0 ^ uh1}, 1);
    chk("z1_aircon", {31'd0, ua0 ^ ua1}, 0);
    chk("z1_fan", {31'd0, ufa0 ^ ufa1}, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
